// File: rtl/lsu_pipe_if.sv
// Bundles the pipeline request/response channels and the memory command/read channels of lsu_pipe.
// Every valid/ready pair transfers on a rising edge where both are high; once a source raises valid it
// keeps valid and its payload stable until that edge (i_mem_rvalid has no ready and is a one-cycle pulse).
interface lsu_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_we;
  logic [1:0]              i_req_size;
  logic                    i_req_unsigned;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [DATA_WIDTH-1:0]   o_rsp_data;
  logic [1:0]              o_rsp_err;
  logic                    o_mem_valid;
  logic                    i_mem_ready;
  logic                    o_mem_we;
  logic [ADDR_WIDTH-1:0]   o_mem_addr;
  logic [DATA_WIDTH/8-1:0] o_mem_be;
  logic [DATA_WIDTH-1:0]   o_mem_wdata;
  logic                    i_mem_rvalid;
  logic [DATA_WIDTH-1:0]   i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_mem_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );
endinterface

// File: rtl/lsu_pipe.sv
// Single-outstanding load/store unit: aligns requests onto memory byte lanes, extends load data,
// and reports misalignment or read timeout through the response error code.
module lsu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  lsu_pipe_if.slave  bus,
  output logic [1:0] o_dbg_state
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int CW    = $clog2(TIMEOUT);
  localparam int MW    = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_we, r_unsigned;
  logic [1:0]            r_size;
  logic [LB-1:0]         r_lane;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LANES-1:0]      r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
  logic [1:0]            r_rsp_err, w_rsp_err_nxt;

  logic                  w_accept, w_bad, w_in_req, w_sign;
  logic [LB-1:0]         w_lane;
  logic [LANES-1:0]      w_be_base;
  logic [MW-1:0]         w_msb;
  logic [DATA_WIDTH-1:0] w_shifted, w_load;

  assign w_accept = (r_state == S_IDLE) && bus.i_req_valid;
  assign w_lane   = bus.i_req_addr[LB-1:0];

  // A dword on a 32-bit path can never be aligned to a lane, so it is rejected like a misaligned access.
  always_comb begin
    w_bad     = 1'b0;
    w_be_base = '0;
    case (bus.i_req_size)
      2'd0: begin w_bad = 1'b0;                                       w_be_base = LANES'(1);     end
      2'd1: begin w_bad = bus.i_req_addr[0];                          w_be_base = LANES'(3);     end
      2'd2: begin w_bad = |bus.i_req_addr[1:0];                       w_be_base = LANES'(15);    end
      default: begin w_bad = (|bus.i_req_addr[2:0]) || (DATA_WIDTH == 32); w_be_base = LANES'(255); end
    endcase
  end

  assign w_shifted = bus.i_mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_msb = MW'(DATA_WIDTH - 1);
    case (r_size)
      2'd0:    w_msb = MW'(7);
      2'd1:    w_msb = MW'(15);
      2'd2:    w_msb = MW'(31);
      default: w_msb = MW'(DATA_WIDTH - 1);
    endcase
  end

  assign w_sign = ~r_unsigned & w_shifted[w_msb];

  always_comb begin
    w_load = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_load[i] = (i <= int'(w_msb)) ? w_shifted[i] : w_sign;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rsp_data_nxt = r_rsp_data;
    w_rsp_err_nxt  = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          if (w_bad) begin
            w_state_nxt    = S_RESP;
            w_rsp_data_nxt = '0;
            w_rsp_err_nxt  = 2'd1;
          end else begin
            w_state_nxt    = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Read data arriving alongside the command handshake is not ours yet; WAIT starts next cycle.
        if (bus.i_mem_ready) begin
          if (r_we) begin
            w_state_nxt    = S_RESP;
            w_rsp_data_nxt = '0;
            w_rsp_err_nxt  = 2'd0;
          end else begin
            w_state_nxt    = S_WAIT;
            w_cnt_nxt      = '0;
          end
        end
      end
      S_WAIT: begin
        if (bus.i_mem_rvalid) begin
          w_state_nxt    = S_RESP;
          w_rsp_data_nxt = w_load;
          w_rsp_err_nxt  = 2'd0;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt    = S_RESP;
          w_rsp_data_nxt = '0;
          w_rsp_err_nxt  = 2'd2;
        end else begin
          w_cnt_nxt      = r_cnt + CW'(1);
        end
      end
      default: begin
        if (bus.i_rsp_ready) begin
          w_state_nxt    = S_IDLE;
          w_rsp_data_nxt = '0;
          w_rsp_err_nxt  = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 2'd0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_lane     <= '0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rsp_data <= w_rsp_data_nxt;
      r_rsp_err  <= w_rsp_err_nxt;
      if (w_accept) begin
        r_we       <= bus.i_req_we;
        r_unsigned <= bus.i_req_unsigned;
        r_size     <= bus.i_req_size;
        r_lane     <= w_lane;
        r_addr     <= {bus.i_req_addr[ADDR_WIDTH-1:LB], LB'(0)};
        r_be       <= w_be_base << w_lane;
        r_wdata    <= bus.i_req_wdata << {w_lane, 3'b000};
      end
    end
  end

  assign w_in_req        = (r_state == S_REQ);
  assign bus.o_req_ready = (r_state == S_IDLE);
  assign bus.o_rsp_valid = (r_state == S_RESP);
  assign bus.o_rsp_data  = r_rsp_data;
  assign bus.o_rsp_err   = r_rsp_err;
  assign bus.o_mem_valid = w_in_req;
  assign bus.o_mem_we    = w_in_req & r_we;
  assign bus.o_mem_addr  = w_in_req ? r_addr  : '0;
  assign bus.o_mem_be    = w_in_req ? r_be    : '0;
  assign bus.o_mem_wdata = w_in_req ? r_wdata : '0;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: a 32-bit instance with a short timeout and a 64-bit instance,
// each driven through its own interface with hand-computed expectations.
module tb_lsu_pipe;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3;

  logic clk = 1'b0;
  logic rst32, rst64;
  logic [1:0] dbg32, dbg64;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
  lsu_pipe_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  lsu_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) u_dut32 (
    .i_clk(clk), .i_rst(rst32), .bus(bus32), .o_dbg_state(dbg32)
  );
  lsu_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(64)) u_dut64 (
    .i_clk(clk), .i_rst(rst64), .bus(bus64), .o_dbg_state(dbg64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req32(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus32.i_req_valid = 1'b1; bus32.i_req_we = we; bus32.i_req_size = size;
    bus32.i_req_unsigned = uns; bus32.i_req_addr = addr; bus32.i_req_wdata = wdata;
    step();
    bus32.i_req_valid = 1'b0;
  endtask

  task automatic req64(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] wdata);
    bus64.i_req_valid = 1'b1; bus64.i_req_we = we; bus64.i_req_size = size;
    bus64.i_req_unsigned = uns; bus64.i_req_addr = addr; bus64.i_req_wdata = wdata;
    step();
    bus64.i_req_valid = 1'b0;
  endtask

  task automatic consume32();
    bus32.i_rsp_ready = 1'b1;
    step();
    bus32.i_rsp_ready = 1'b0;
  endtask

  task automatic consume64();
    bus64.i_rsp_ready = 1'b1;
    step();
    bus64.i_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus32.i_req_valid = 0; bus32.i_req_we = 0; bus32.i_req_size = 0; bus32.i_req_unsigned = 0;
    bus32.i_req_addr = 0; bus32.i_req_wdata = 0; bus32.i_rsp_ready = 0; bus32.i_mem_ready = 0;
    bus32.i_mem_rvalid = 0; bus32.i_mem_rdata = 0;
    bus64.i_req_valid = 0; bus64.i_req_we = 0; bus64.i_req_size = 0; bus64.i_req_unsigned = 0;
    bus64.i_req_addr = 0; bus64.i_req_wdata = 0; bus64.i_rsp_ready = 0; bus64.i_mem_ready = 0;
    bus64.i_mem_rvalid = 0; bus64.i_mem_rdata = 0;
    rst32 = 1'b1; rst64 = 1'b1;
    step(); step();
    rst32 = 1'b0; rst64 = 1'b0;

    // reset state
    chk("rst_state", dbg32, ST_IDLE);
    chk("rst_req_ready", bus32.o_req_ready, 1);
    chk("rst_rsp_valid", bus32.o_rsp_valid, 0);
    chk("rst_mem_valid", bus32.o_mem_valid, 0);
    chk("rst_mem_be", bus32.o_mem_be, 0);
    chk("rst_rsp_data", bus32.o_rsp_data, 0);
    chk("rst_rsp_err", bus32.o_rsp_err, 0);

    // LB 0x103 signed; stray rvalid during the command handshake must be ignored
    req32(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    chk("lb_req_ready", bus32.o_req_ready, 0);
    chk("lb_mem_valid", bus32.o_mem_valid, 1);
    chk("lb_mem_addr", bus32.o_mem_addr, 32'h100);
    chk("lb_mem_be", bus32.o_mem_be, 4'b1000);
    chk("lb_mem_we", bus32.o_mem_we, 0);
    bus32.i_mem_ready = 1'b1; bus32.i_mem_rvalid = 1'b1; bus32.i_mem_rdata = 32'hDEAD_BEEF;
    step();
    bus32.i_mem_ready = 1'b0;
    chk("lb_wait_state", dbg32, ST_WAIT);
    chk("lb_wait_mem_be", bus32.o_mem_be, 0);
    chk("lb_wait_rsp_valid", bus32.o_rsp_valid, 0);
    bus32.i_mem_rvalid = 1'b1; bus32.i_mem_rdata = 32'h80FF_1234;
    step();
    bus32.i_mem_rvalid = 1'b0;
    chk("lb_rsp_valid", bus32.o_rsp_valid, 1);
    chk("lb_rsp_data", bus32.o_rsp_data, 32'hFFFF_FF80);
    chk("lb_rsp_err", bus32.o_rsp_err, 0);
    consume32();
    chk("lb_back_idle", bus32.o_req_ready, 1);

    // LHU 0x202
    req32(1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
    chk("lhu_mem_addr", bus32.o_mem_addr, 32'h200);
    chk("lhu_mem_be", bus32.o_mem_be, 4'b1100);
    bus32.i_mem_ready = 1'b1;
    step();
    bus32.i_mem_ready = 1'b0;
    bus32.i_mem_rvalid = 1'b1; bus32.i_mem_rdata = 32'hBEEF_0000;
    step();
    bus32.i_mem_rvalid = 1'b0;
    chk("lhu_rsp_data", bus32.o_rsp_data, 32'h0000_BEEF);
    chk("lhu_rsp_err", bus32.o_rsp_err, 0);
    consume32();

    // SH 0x006 with memory ready on the third command cycle
    req32(1'b1, 2'd1, 1'b0, 32'h006, 32'h0000_1234);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus32.i_mem_ready = 1'b1;
      chk($sformatf("sh_mem_valid_%0d", k), bus32.o_mem_valid, 1);
      chk($sformatf("sh_mem_we_%0d", k), bus32.o_mem_we, 1);
      chk($sformatf("sh_mem_addr_%0d", k), bus32.o_mem_addr, 32'h004);
      chk($sformatf("sh_mem_be_%0d", k), bus32.o_mem_be, 4'b1100);
      chk($sformatf("sh_mem_wdata_%0d", k), bus32.o_mem_wdata, 32'h1234_0000);
      step();
    end
    bus32.i_mem_ready = 1'b0;
    chk("sh_rsp_valid", bus32.o_rsp_valid, 1);
    chk("sh_rsp_data", bus32.o_rsp_data, 0);
    chk("sh_rsp_err", bus32.o_rsp_err, 0);
    chk("sh_mem_valid_off", bus32.o_mem_valid, 0);
    chk("sh_mem_wdata_off", bus32.o_mem_wdata, 0);
    consume32();

    // misaligned LW, then illegal dword on a 32-bit path
    req32(1'b0, 2'd2, 1'b0, 32'h001, 32'h0);
    chk("lw_mis_state", dbg32, ST_RESP);
    chk("lw_mis_mem_valid", bus32.o_mem_valid, 0);
    chk("lw_mis_err", bus32.o_rsp_err, 1);
    chk("lw_mis_data", bus32.o_rsp_data, 0);
    consume32();
    req32(1'b1, 2'd3, 1'b0, 32'h000, 32'h0);
    chk("sd_ill_state", dbg32, ST_RESP);
    chk("sd_ill_mem_valid", bus32.o_mem_valid, 0);
    chk("sd_ill_err", bus32.o_rsp_err, 1);
    consume32();

    // timeout after 4 WAIT cycles, late rvalid ignored, then a normal load
    req32(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
    bus32.i_mem_ready = 1'b1;
    step();
    bus32.i_mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_wait_%0d", k), dbg32, ST_WAIT);
      step();
    end
    chk("to_rsp_valid", bus32.o_rsp_valid, 1);
    chk("to_rsp_err", bus32.o_rsp_err, 2);
    chk("to_rsp_data", bus32.o_rsp_data, 0);
    bus32.i_mem_rvalid = 1'b1; bus32.i_mem_rdata = 32'h0000_0055;
    step();
    chk("to_late_err", bus32.o_rsp_err, 2);
    chk("to_late_data", bus32.o_rsp_data, 0);
    consume32();
    chk("to_late_idle", dbg32, ST_IDLE);
    step();
    bus32.i_mem_rvalid = 1'b0;
    chk("to_late_no_rsp", bus32.o_rsp_valid, 0);
    req32(1'b0, 2'd2, 1'b0, 32'h020, 32'h0);
    chk("after_to_mem_addr", bus32.o_mem_addr, 32'h020);
    bus32.i_mem_ready = 1'b1;
    step();
    bus32.i_mem_ready = 1'b0;
    bus32.i_mem_rvalid = 1'b1; bus32.i_mem_rdata = 32'hCAFE_F00D;
    step();
    bus32.i_mem_rvalid = 1'b0;
    chk("after_to_data", bus32.o_rsp_data, 32'hCAFE_F00D);
    chk("after_to_err", bus32.o_rsp_err, 0);
    consume32();

    // 64-bit: LD 0x08 with a stalled consumer
    req64(1'b0, 2'd3, 1'b0, 32'h008, 64'h0);
    chk("ld_mem_addr", bus64.o_mem_addr, 32'h008);
    chk("ld_mem_be", bus64.o_mem_be, 8'hFF);
    bus64.i_mem_ready = 1'b1;
    step();
    bus64.i_mem_ready = 1'b0;
    bus64.i_mem_rvalid = 1'b1; bus64.i_mem_rdata = 64'h8123_4567_89AB_CDEF;
    step();
    bus64.i_mem_rvalid = 1'b0; bus64.i_mem_rdata = 64'h0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ld_hold_valid_%0d", k), bus64.o_rsp_valid, 1);
      chk($sformatf("ld_hold_data_%0d", k), bus64.o_rsp_data, 64'h8123_4567_89AB_CDEF);
      chk($sformatf("ld_hold_err_%0d", k), bus64.o_rsp_err, 0);
      step();
    end
    consume64();

    // 64-bit: LW 0x0C abandoned by reset mid-WAIT
    req64(1'b0, 2'd2, 1'b0, 32'h00C, 64'h0);
    chk("lw64_mem_addr", bus64.o_mem_addr, 32'h008);
    chk("lw64_mem_be", bus64.o_mem_be, 8'hF0);
    bus64.i_mem_ready = 1'b1;
    step();
    bus64.i_mem_ready = 1'b0;
    step();
    chk("lw64_in_wait", dbg64, ST_WAIT);
    rst64 = 1'b1;
    step();
    rst64 = 1'b0;
    chk("rst64_state", dbg64, ST_IDLE);
    chk("rst64_req_ready", bus64.o_req_ready, 1);
    chk("rst64_rsp_valid", bus64.o_rsp_valid, 0);
    chk("rst64_mem_valid", bus64.o_mem_valid, 0);
    chk("rst64_rsp_data", bus64.o_rsp_data, 0);
    bus64.i_mem_rvalid = 1'b1; bus64.i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus64.i_mem_rvalid = 1'b0;
    chk("rst64_late_rvalid", bus64.o_rsp_valid, 0);
    chk("rst64_late_state", dbg64, ST_IDLE);

    // 64-bit: signed LW from the upper lanes
    req64(1'b0, 2'd2, 1'b0, 32'h00C, 64'h0);
    bus64.i_mem_ready = 1'b1;
    step();
    bus64.i_mem_ready = 1'b0;
    bus64.i_mem_rvalid = 1'b1; bus64.i_mem_rdata = 64'h8000_0000_1111_2222;
    step();
    bus64.i_mem_rvalid = 1'b0;
    chk("lw64_data", bus64.o_rsp_data, 64'hFFFF_FFFF_8000_0000);
    chk("lw64_err", bus64.o_rsp_err, 0);
    consume64();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
